// File: rtl/npc_unit.sv
// Fetch-PC generator: owns f_pc, selects the next PC from the D-stage decision,
// and keeps a return-address stack that checks each jr target against its jal.
module npc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       d_op,
  input  logic [31:0]      d_pc,
  input  logic             d_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [31:0]      rs_val,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [31:0]      epc,
  output logic [31:0]      f_pc,
  output logic [31:0]      npc,
  output logic             f_adel,
  output logic             ras_mismatch,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [RAS_DEPTH-1:0][31:0] ras;
  logic [PW-1:0]              ptr;
  logic [CW-1:0]              cnt;
  logic [31:0]                br_tgt, j_tgt, top;
  logic                       act, push, pop, mis;

  assign br_tgt = d_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {d_pc[31:28], imm26, 2'b00};
  assign f_adel = |f_pc[1:0];

  // Redirects and stalls freeze the stack so a squashed call/return leaves no trace.
  assign act  = !stall && !exc_req && !eret;
  assign push = act && (d_op == 3'b011);
  assign pop  = act && (d_op == 3'b100);
  assign top  = ras[ptr - 1'b1];
  assign mis  = pop && ((cnt == '0) || (top != rs_val));

  always_comb begin
    npc = f_pc + 32'd4;
    if (exc_req)    npc = EXC_PC;
    else if (eret)  npc = epc;
    else if (stall) npc = f_pc;
    else begin
      case (d_op)
        3'b001:         if (d_taken) npc = br_tgt;
        3'b010, 3'b011: npc = j_tgt;
        3'b100:         npc = rs_val;
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc         <= RESET_PC;
      ptr          <= '0;
      cnt          <= '0;
      ras          <= '0;
      ras_mismatch <= 1'b0;
      miss_cnt     <= '0;
    end else begin
      f_pc         <= npc;
      ras_mismatch <= mis;
      if (mis && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      // Full stack keeps pushing: oldest entry is overwritten, count saturates.
      if (push) begin
        ras[ptr] <= d_pc + 32'd8;
        ptr      <= ptr + 1'b1;
        if (cnt != CW'(RAS_DEPTH)) cnt <= cnt + 1'b1;
      end else if (pop && (cnt != '0)) begin
        ptr <= ptr - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_npc_unit.sv
// Bench for npc_unit: directed vector table, hand sequences, and random
// stimulus against a queue-based reference model.
module tb_npc_unit;
  localparam int CNTW  = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] EXC = 32'h0000_4180;

  logic clk = 1'b0, reset, stall, d_taken, exc_req, eret;
  logic [2:0] d_op;
  logic [31:0] d_pc, rs_val, epc, f_pc, npc;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic f_adel, ras_mismatch;
  logic [CNTW-1:0] miss_cnt;

  int n_chk = 0, n_fail = 0;

  npc_unit #(.RESET_PC(RST), .EXC_PC(EXC), .RAS_DEPTH(DEPTH), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .d_op(d_op), .d_pc(d_pc),
    .d_taken(d_taken), .imm16(imm16), .imm26(imm26), .rs_val(rs_val),
    .exc_req(exc_req), .eret(eret), .epc(epc), .f_pc(f_pc), .npc(npc),
    .f_adel(f_adel), .ras_mismatch(ras_mismatch), .miss_cnt(miss_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic st, ex, er; logic [2:0] op; logic tk;
    logic [31:0] dpc; logic [15:0] i16; logic [25:0] i26; logic [31:0] rs, ep;
    logic [31:0] e_pc; logic e_adel; logic e_mis; logic [CNTW-1:0] e_cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, ex, er, input logic [2:0] op, input logic tk,
                       input logic [31:0] dpc, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs, ep);
    stall = st; exc_req = ex; eret = er; d_op = op; d_taken = tk;
    d_pc = dpc; imm16 = i16; imm26 = i26; rs_val = rs; epc = ep;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic add(input logic st, ex, er, input logic [2:0] op, input logic tk,
                     input logic [31:0] dpc, input logic [15:0] i16, input logic [25:0] i26,
                     input logic [31:0] rs, ep, e_pc, input logic e_mis, input int e_cnt);
    vec_t v;
    v.st = st; v.ex = ex; v.er = er; v.op = op; v.tk = tk; v.dpc = dpc; v.i16 = i16;
    v.i26 = i26; v.rs = rs; v.ep = ep; v.e_pc = e_pc; v.e_adel = |e_pc[1:0];
    v.e_mis = e_mis; v.e_cnt = CNTW'(e_cnt);
    vecs.push_back(v);
  endtask

  // reference model state
  logic [31:0] m_pc, m_npc;
  logic [31:0] m_q[$];
  logic m_mis;
  int   m_cnt;

  initial begin
    reset = 1'b1;
    drive(0,0,0,3'b000,0,32'h0,16'h0,26'h0,32'h0,32'h0);
    cyc(); cyc();
    chk("reset_fpc", f_pc, RST);
    chk("reset_mis", {31'b0, ras_mismatch}, 32'd0);
    chk("reset_cnt", {28'b0, miss_cnt}, 32'd0);
    chk("reset_adel", {31'b0, f_adel}, 32'd0);
    reset = 1'b0;

    //  st ex er op   tk dpc           i16       i26          rs            ep            e_pc        mis cnt
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3004,     0,0);
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3008,     0,0);
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h300C,     0,0);
    add(0,0,0,3'd1,1,32'h3010,     16'hFFFE, 26'h0,       32'h0,        32'h0,        32'h300C,     0,0);
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3010,     0,0);
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3014,     0,0);
    add(0,0,0,3'd1,0,32'h3010,     16'hFFFE, 26'h0,       32'h0,        32'h0,        32'h3018,     0,0);
    add(0,0,0,3'd3,0,32'h3020,     16'h0,    26'h0C40,    32'h0,        32'h0,        32'h3100,     0,0);
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3104,     0,0);
    add(0,0,0,3'd4,0,32'h0,        16'h0,    26'h0,       32'h3028,     32'h0,        32'h3028,     0,0);
    add(0,0,0,3'd3,0,32'h3020,     16'h0,    26'h0C40,    32'h0,        32'h0,        32'h3100,     0,0);
    add(0,0,0,3'd4,0,32'h0,        16'h0,    26'h0,       32'h3030,     32'h0,        32'h3030,     1,1);
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3034,     0,1);
    add(0,0,0,3'd5,1,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3038,     0,1);
    add(1,0,0,3'd3,0,32'h3000,     16'h0,    26'h0C40,    32'h0,        32'h0,        32'h3038,     0,1);
    add(1,0,0,3'd3,0,32'h3000,     16'h0,    26'h0C40,    32'h0,        32'h0,        32'h3038,     0,1);
    add(1,0,0,3'd3,0,32'h3000,     16'h0,    26'h0C40,    32'h0,        32'h0,        32'h3038,     0,1);
    add(1,1,0,3'd3,0,32'h3000,     16'h0,    26'h0C40,    32'h0,        32'h0,        EXC,          0,1);
    add(0,0,1,3'd4,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h3044,     32'h3044,     0,1);
    // empty stack here, so this jr is an underflow as well as misaligned
    add(0,0,0,3'd4,0,32'h0,        16'h0,    26'h0,       32'h3002,     32'h0,        32'h3002,     1,2);
    add(0,0,0,3'd2,0,32'hF000_0000,16'h0,    26'h3FF_FFFF,32'h0,        32'h0,        32'hFFFF_FFFC,0,2);
    add(0,0,0,3'd0,0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h0,        0,2);
    add(0,1,0,3'd3,0,32'h100,      16'h0,    26'h0,       32'h0,        32'h0,        EXC,          0,2);
    add(0,0,0,3'd4,0,32'h0,        16'h0,    26'h0,       32'h108,      32'h0,        32'h108,      1,3);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].ex, vecs[i].er, vecs[i].op, vecs[i].tk, vecs[i].dpc,
            vecs[i].i16, vecs[i].i26, vecs[i].rs, vecs[i].ep);
      cyc();
      chk($sformatf("vec%0d_fpc", i), f_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_adel", i), {31'b0, f_adel}, {31'b0, vecs[i].e_adel});
      chk($sformatf("vec%0d_mis", i), {31'b0, ras_mismatch}, {31'b0, vecs[i].e_mis});
      chk($sformatf("vec%0d_cnt", i), {28'b0, miss_cnt}, {28'b0, vecs[i].e_cnt});
    end

    // misaligned jr then reset with stall held
    drive(0,0,0,3'd4,0,32'h0,16'h0,26'h0,32'h3002,32'h0);
    cyc();
    chk("jr_mis_adel", {31'b0, f_adel}, 32'd1);
    reset = 1'b1; drive(1,0,0,3'd3,0,32'h3000,16'h0,26'h0,32'h0,32'h0);
    cyc();
    reset = 1'b0;
    chk("rst_stall_fpc", f_pc, RST);
    chk("rst_stall_adel", {31'b0, f_adel}, 32'd0);
    chk("rst_stall_cnt", {28'b0, miss_cnt}, 32'd0);
    chk("rst_stall_mis", {31'b0, ras_mismatch}, 32'd0);

    // five pushes into a four-deep stack, then five pops
    for (int i = 0; i < 5; i++) begin
      drive(0,0,0,3'd3,0,32'h3000 + 32'h10 * i,16'h0,26'h0C40,32'h0,32'h0);
      cyc();
    end
    for (int k = 0; k < 5; k++) begin
      drive(0,0,0,3'd4,0,32'h0,16'h0,26'h0,32'h3048 - 32'h10 * k,32'h0);
      cyc();
      chk($sformatf("ovf_pop%0d_mis", k), {31'b0, ras_mismatch}, (k == 4) ? 32'd1 : 32'd0);
    end
    drive(0,0,0,3'd0,0,32'h0,16'h0,26'h0,32'h0,32'h0);
    cyc();
    chk("ovf_pulse_end", {31'b0, ras_mismatch}, 32'd0);
    chk("ovf_cnt", {28'b0, miss_cnt}, 32'd1);

    // random phase vs reference model
    reset = 1'b1; cyc(); reset = 1'b0;
    m_pc = RST; m_q.delete(); m_mis = 1'b0; m_cnt = 0;
    for (int t = 0; t < 3000; t++) begin
      logic [31:0] rs;
      logic [2:0] op;
      logic st, ex, er, tk, rst_now, act;
      op = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 7) == 0);
      ex = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 15) == 0);
      tk = 1'($urandom);
      rst_now = ($urandom_range(0, 199) == 0);
      rs = $urandom;
      if (m_q.size() > 0 && $urandom_range(0, 2) != 0) rs = m_q[m_q.size()-1];
      drive(st, ex, er, op, tk, $urandom & 32'hFFFF_FFFC, 16'($urandom), 26'($urandom), rs, $urandom);
      reset = rst_now;
      #1;
      if (ex)                       m_npc = EXC;
      else if (er)                  m_npc = epc;
      else if (st)                  m_npc = m_pc;
      else if (op == 3'd1 && tk)    m_npc = d_pc + 4 + (32'(signed'(imm16)) << 2);
      else if (op == 3'd2 || op == 3'd3) m_npc = {d_pc[31:28], imm26, 2'b00};
      else if (op == 3'd4)          m_npc = rs_val;
      else                          m_npc = m_pc + 4;
      chk("rnd_npc", npc, m_npc);
      act = !st && !ex && !er;
      if (rst_now) begin
        m_pc = RST; m_q.delete(); m_mis = 1'b0; m_cnt = 0;
      end else begin
        m_pc = m_npc;
        m_mis = 1'b0;
        if (act && op == 3'd3) begin
          m_q.push_back(d_pc + 8);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
        end else if (act && op == 3'd4) begin
          if (m_q.size() == 0) m_mis = 1'b1;
          else m_mis = (m_q.pop_back() != rs_val);
        end
        if (m_mis && m_cnt < (1 << CNTW) - 1) m_cnt++;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rnd_fpc", f_pc, m_pc);
      chk("rnd_adel", {31'b0, f_adel}, {31'b0, |m_pc[1:0]});
      chk("rnd_mis", {31'b0, ras_mismatch}, {31'b0, m_mis});
      chk("rnd_cnt", {28'b0, miss_cnt}, 32'(m_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
